// File: rtl/ifetch_stage.sv
// DLX instruction-fetch stage: owns the PC, runs the imem request/ready handshake and feeds the IF/ID register.
// Define IFETCH_PERF_EN to add the saturating perf_fetched / perf_bubbles counters.
module ifetch_stage #(
  parameter logic [0:31] RESET_PC  = 32'h0000_0000,
  parameter logic [0:31] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [0:31] imem_addr,
  input  logic [0:31] imem_data,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [0:31] redirect_pc,
  output logic        if_id_valid,
  output logic [0:31] if_id_instr,
  output logic [0:31] if_id_pc4,
  output logic [0:5]  OpCode,
  output logic [0:5]  Function
`ifdef IFETCH_PERF_EN
  ,
  output logic [0:31] perf_fetched,
  output logic [0:31] perf_bubbles
`endif
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]  r_state, w_state_nxt;
  logic [0:31] r_pc, w_pc_nxt;
  logic [0:31] r_addr, w_addr_nxt;
  logic        r_req, w_req_nxt;
  logic        r_valid, w_valid_nxt;
  logic [0:31] r_instr, w_instr_nxt;
  logic [0:31] r_pc4, w_pc4_nxt;
  logic [0:31] r_hold_buf;
  logic        w_hold_ld;
  logic        w_ack;
  logic        w_load;
  logic [0:31] w_pc_plus4;
  logic [0:31] w_redir_pc;

  assign w_ack      = r_req & imem_ready;
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_redir_pc = redirect_pc & 32'hFFFF_FFFC;

  // A real instruction enters IF/ID either straight from memory or from the buffer parked during a stall.
  assign w_load = !redirect_valid && !stall &&
                  ((r_state == S_FETCH && w_ack) || r_state == S_HOLD);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_addr_nxt  = r_addr;
    w_req_nxt   = r_req;
    w_valid_nxt = r_valid;
    w_instr_nxt = r_instr;
    w_pc4_nxt   = r_pc4;
    w_hold_ld   = 1'b0;

    if (redirect_valid) begin
      w_valid_nxt = 1'b0;
      w_instr_nxt = NOP_INSTR;
      w_pc_nxt    = w_redir_pc;
      // An unanswered request is never abandoned: keep its address and wait it out in DRAIN.
      if (r_state == S_DRAIN || (r_state == S_FETCH && r_req && !imem_ready)) begin
        w_state_nxt = S_DRAIN;
      end else begin
        w_state_nxt = S_FETCH;
        w_addr_nxt  = w_redir_pc;
        w_req_nxt   = 1'b1;
      end
    end else begin
      case (r_state)
        S_FETCH: begin
          w_req_nxt = 1'b1;
          if (w_ack && stall) begin
            w_hold_ld   = 1'b1;
            w_state_nxt = S_HOLD;
            w_req_nxt   = 1'b0;
          end else if (!w_ack && !stall) begin
            w_valid_nxt = 1'b0;
            w_instr_nxt = NOP_INSTR;
          end
        end
        S_HOLD: begin
          w_req_nxt = 1'b0;
        end
        S_DRAIN: begin
          w_valid_nxt = 1'b0;
          w_instr_nxt = NOP_INSTR;
          if (w_ack) begin
            w_state_nxt = S_FETCH;
            w_addr_nxt  = r_pc;
          end
        end
        default: begin
          w_state_nxt = S_FETCH;
        end
      endcase

      if (w_load) begin
        w_valid_nxt = 1'b1;
        w_instr_nxt = (r_state == S_HOLD) ? r_hold_buf : imem_data;
        w_pc4_nxt   = w_pc_plus4;
        w_pc_nxt    = w_pc_plus4;
        w_addr_nxt  = w_pc_plus4;
        w_state_nxt = S_FETCH;
        w_req_nxt   = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_addr  <= RESET_PC;
      r_req   <= 1'b0;
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
      r_pc4   <= 32'h0000_0000;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_addr  <= w_addr_nxt;
      r_req   <= w_req_nxt;
      r_valid <= w_valid_nxt;
      r_instr <= w_instr_nxt;
      r_pc4   <= w_pc4_nxt;
    end
  end

  // NOTE: the hold buffer is a pure data register with no reset; it is only read after being written.
  always_ff @(posedge clk) begin
    if (w_hold_ld) r_hold_buf <= imem_data;
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_addr;
  assign if_id_valid = r_valid;
  assign if_id_instr = r_instr;
  assign if_id_pc4   = r_pc4;
  assign OpCode      = r_instr[0:5];
  assign Function    = r_instr[26:31];

`ifdef IFETCH_PERF_EN
  logic [0:31] r_perf_fetched;
  logic [0:31] r_perf_bubbles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetched <= 32'h0000_0000;
      r_perf_bubbles <= 32'h0000_0000;
    end else begin
      if (w_load && r_perf_fetched != '1) r_perf_fetched <= r_perf_fetched + 32'd1;
      if (!w_valid_nxt && !stall && r_perf_bubbles != '1) r_perf_bubbles <= r_perf_bubbles + 32'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_bubbles = r_perf_bubbles;
`endif

endmodule

// File: tb/tb_ifetch_stage.sv
// Self-checking bench for ifetch_stage: directed vector table, hand-written corner sequences,
// then randomized handshake/stall/redirect traffic against a transaction-level model.
module tb_ifetch_stage;

  localparam logic [0:31] RESET_PC  = 32'h0000_0000;
  localparam logic [0:31] NOP_INSTR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [0:31] imem_addr;
  logic [0:31] imem_data;
  logic        imem_ready;
  logic        stall;
  logic        redirect_valid;
  logic [0:31] redirect_pc;
  logic        if_id_valid;
  logic [0:31] if_id_instr;
  logic [0:31] if_id_pc4;
  logic [0:5]  OpCode;
  logic [0:5]  Function;
`ifdef IFETCH_PERF_EN
  logic [0:31] perf_fetched;
  logic [0:31] perf_bubbles;
`endif

  ifetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data), .imem_ready(imem_ready),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
    .OpCode(OpCode), .Function(Function)
`ifdef IFETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed word at 0, an address-derived pattern elsewhere.
  function automatic logic [0:31] instr_at(input logic [0:31] a);
    if (a == 32'h0) return 32'h2001_0004;
    return a ^ 32'h8C00_5A5A;
  endfunction

  assign imem_data = instr_at(imem_addr);

  int n_vec;
  int n_miss;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rdy, stl, rv;
    logic [0:31] rpc;
    logic        e_req;
    logic [0:31] e_addr;
    logic        e_valid;
    logic [0:31] e_instr;
    logic [0:31] e_pc4;
  } vec_t;

  function automatic vec_t mk(input logic rdy, stl, rv, input logic [0:31] rpc,
                              input logic e_req, input logic [0:31] e_addr,
                              input logic e_valid, input logic [0:31] e_instr, e_pc4);
    vec_t v;
    v.rdy = rdy; v.stl = stl; v.rv = rv; v.rpc = rpc;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_instr = e_instr; v.e_pc4 = e_pc4;
    return v;
  endfunction

  vec_t vecs[23];

  // Transaction-level reference: outstanding request, a response marked for discard, a parked word.
  logic        m_req, m_discard, m_valid;
  logic [0:31] m_pc, m_addr, m_instr, m_pc4;
  logic [0:31] m_fetched, m_bubbles;
  logic [0:31] held[$];

  task automatic model_reset();
    m_req = 1'b0; m_discard = 1'b0; m_valid = 1'b0;
    m_pc = RESET_PC; m_addr = RESET_PC; m_instr = NOP_INSTR; m_pc4 = 32'h0;
    m_fetched = 32'h0; m_bubbles = 32'h0;
    held.delete();
  endtask

  task automatic model_step(input logic rdy, stl, rv, input logic [0:31] rpc);
    logic        ack;
    logic        loaded;
    logic [0:31] tgt;
    ack    = m_req && rdy;
    loaded = 1'b0;
    tgt    = {rpc[0:29], 2'b00};
    if (rv) begin
      m_valid = 1'b0; m_instr = NOP_INSTR; held.delete();
      m_pc = tgt;
      if (m_discard || (m_req && !rdy)) m_discard = 1'b1;
      else begin m_addr = tgt; m_req = 1'b1; end
    end else if (held.size() != 0) begin
      if (!stl) begin
        m_instr = held.pop_front(); m_valid = 1'b1; m_pc4 = m_pc + 32'd4;
        m_pc = m_pc4; m_addr = m_pc4; m_req = 1'b1; loaded = 1'b1;
      end
    end else if (m_discard) begin
      m_valid = 1'b0; m_instr = NOP_INSTR;
      if (ack) begin m_discard = 1'b0; m_addr = m_pc; end
    end else if (ack && stl) begin
      held.push_back(instr_at(m_addr)); m_req = 1'b0;
    end else begin
      m_req = 1'b1;
      if (ack) begin
        m_instr = instr_at(m_addr); m_valid = 1'b1; m_pc4 = m_pc + 32'd4;
        m_pc = m_pc4; m_addr = m_pc4; loaded = 1'b1;
      end else if (!stl) begin
        m_valid = 1'b0; m_instr = NOP_INSTR;
      end
    end
    if (loaded && m_fetched != 32'hFFFF_FFFF) m_fetched = m_fetched + 32'd1;
    if (!m_valid && !stl && m_bubbles != 32'hFFFF_FFFF) m_bubbles = m_bubbles + 32'd1;
  endtask

  task automatic compare_model();
    logic [0:31] ei;
    ei = m_instr;
    check("rnd_req", 32'(imem_req), 32'(m_req));
    if (m_req) check("rnd_addr", imem_addr, m_addr);
    check("rnd_valid", 32'(if_id_valid), 32'(m_valid));
    check("rnd_instr", if_id_instr, m_instr);
    if (m_valid) check("rnd_pc4", if_id_pc4, m_pc4);
    check("rnd_opcode", 32'(OpCode), 32'(ei[0:5]));
    check("rnd_function", 32'(Function), 32'(ei[26:31]));
`ifdef IFETCH_PERF_EN
    check("rnd_perf_fetched", perf_fetched, m_fetched);
    check("rnd_perf_bubbles", perf_bubbles, m_bubbles);
`endif
  endtask

  task automatic drive(input logic rdy, stl, rv, input logic [0:31] rpc);
    imem_ready = rdy; stall = stl; redirect_valid = rv; redirect_pc = rpc;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_valid", 32'(if_id_valid), 32'h0);
    check("rst_instr", if_id_instr, NOP_INSTR);
    check("rst_pc4", if_id_pc4, 32'h0);
`ifdef IFETCH_PERF_EN
    check("rst_perf_fetched", perf_fetched, 32'h0);
    check("rst_perf_bubbles", perf_bubbles, 32'h0);
`endif
    rst_n = 1'b1;
  endtask

  initial begin
    logic        prev_rv;
    logic        rdy, stl, rv;
    logic [0:31] rpc;
    logic [0:31] ei;

    n_vec = 0;
    n_miss = 0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);

    //              rdy  stl  rv   rpc             req  addr            vld  instr                       pc4
    vecs[0]  = mk(1'b1,1'b0,1'b0,32'h0,          1'b1,32'h0,          1'b0,NOP_INSTR,                 32'h0);
    vecs[1]  = mk(1'b1,1'b0,1'b0,32'h0,          1'b1,32'h4,          1'b1,32'h2001_0004,             32'h4);
    vecs[2]  = mk(1'b0,1'b0,1'b0,32'h0,          1'b1,32'h4,          1'b0,NOP_INSTR,                 32'h0);
    vecs[3]  = mk(1'b0,1'b0,1'b0,32'h0,          1'b1,32'h4,          1'b0,NOP_INSTR,                 32'h0);
    vecs[4]  = mk(1'b0,1'b0,1'b0,32'h0,          1'b1,32'h4,          1'b0,NOP_INSTR,                 32'h0);
    vecs[5]  = mk(1'b1,1'b0,1'b0,32'h0,          1'b1,32'h8,          1'b1,instr_at(32'h4),           32'h8);
    vecs[6]  = mk(1'b1,1'b1,1'b0,32'h0,          1'b0,32'h0,          1'b1,instr_at(32'h4),           32'h8);
    vecs[7]  = mk(1'b1,1'b1,1'b0,32'h0,          1'b0,32'h0,          1'b1,instr_at(32'h4),           32'h8);
    vecs[8]  = mk(1'b1,1'b0,1'b0,32'h0,          1'b1,32'hC,          1'b1,instr_at(32'h8),           32'hC);
    vecs[9]  = mk(1'b0,1'b0,1'b0,32'h0,          1'b1,32'hC,          1'b0,NOP_INSTR,                 32'h0);
    vecs[10] = mk(1'b0,1'b0,1'b1,32'h0000_0103,  1'b1,32'hC,          1'b0,NOP_INSTR,                 32'h0);
    vecs[11] = mk(1'b1,1'b0,1'b0,32'h0,          1'b1,32'h100,        1'b0,NOP_INSTR,                 32'h0);
    vecs[12] = mk(1'b1,1'b0,1'b0,32'h0,          1'b1,32'h104,        1'b1,instr_at(32'h100),         32'h104);
    vecs[13] = mk(1'b1,1'b1,1'b1,32'h0000_0202,  1'b1,32'h200,        1'b0,NOP_INSTR,                 32'h0);
    vecs[14] = mk(1'b1,1'b0,1'b0,32'h0,          1'b1,32'h204,        1'b1,instr_at(32'h200),         32'h204);
    vecs[15] = mk(1'b1,1'b1,1'b0,32'h0,          1'b0,32'h0,          1'b1,instr_at(32'h200),         32'h204);
    vecs[16] = mk(1'b0,1'b1,1'b1,32'hFFFF_FFFC,  1'b1,32'hFFFF_FFFC,  1'b0,NOP_INSTR,                 32'h0);
    vecs[17] = mk(1'b1,1'b0,1'b0,32'h0,          1'b1,32'h0,          1'b1,instr_at(32'hFFFF_FFFC),   32'h0);
    vecs[18] = mk(1'b0,1'b0,1'b0,32'h0,          1'b1,32'h0,          1'b0,NOP_INSTR,                 32'h0);
    vecs[19] = mk(1'b0,1'b0,1'b1,32'h0000_0040,  1'b1,32'h0,          1'b0,NOP_INSTR,                 32'h0);
    vecs[20] = mk(1'b0,1'b0,1'b1,32'h0000_0080,  1'b1,32'h0,          1'b0,NOP_INSTR,                 32'h0);
    vecs[21] = mk(1'b1,1'b0,1'b0,32'h0,          1'b1,32'h80,         1'b0,NOP_INSTR,                 32'h0);
    vecs[22] = mk(1'b1,1'b0,1'b0,32'h0,          1'b1,32'h84,         1'b1,instr_at(32'h80),          32'h84);

    reset_dut();

    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].rdy, vecs[i].stl, vecs[i].rv, vecs[i].rpc);
      step();
      ei = vecs[i].e_instr;
      check($sformatf("vec%0d_req", i), 32'(imem_req), 32'(vecs[i].e_req));
      if (vecs[i].e_req) check($sformatf("vec%0d_addr", i), imem_addr, vecs[i].e_addr);
      check($sformatf("vec%0d_valid", i), 32'(if_id_valid), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d_instr", i), if_id_instr, vecs[i].e_instr);
      if (vecs[i].e_valid) check($sformatf("vec%0d_pc4", i), if_id_pc4, vecs[i].e_pc4);
      check($sformatf("vec%0d_opcode", i), 32'(OpCode), 32'(ei[0:5]));
      check($sformatf("vec%0d_function", i), 32'(Function), 32'(ei[26:31]));
      if (i == 1) check("first_opcode_08", 32'(OpCode), 32'h08);
    end

    // Reset while draining a redirected request, then a fetch across the address wrap.
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0300);
    step();
    check("drain_req", 32'(imem_req), 32'h1);
    check("drain_stale_addr", imem_addr, 32'h84);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_req", 32'(imem_req), 32'h0);
    check("midrst_addr", imem_addr, RESET_PC);
    check("midrst_valid", 32'(if_id_valid), 32'h0);
    check("midrst_instr", if_id_instr, NOP_INSTR);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("postrst_req_low", 32'(imem_req), 32'h0);
    @(negedge clk);
    step();
    check("postrst_req_high", 32'(imem_req), 32'h1);
    check("postrst_addr", imem_addr, RESET_PC);
    drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
    step();
    check("wrap_redir_addr", imem_addr, 32'hFFFF_FFFC);
    check("wrap_redir_valid", 32'(if_id_valid), 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    check("wrap_valid", 32'(if_id_valid), 32'h1);
    check("wrap_instr", if_id_instr, instr_at(32'hFFFF_FFFC));
    check("wrap_pc4", if_id_pc4, 32'h0);
    check("wrap_next_addr", imem_addr, 32'h0);

    // Randomized traffic against the reference model.
    reset_dut();
    model_reset();
    prev_rv = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      compare_model();
      rdy = ($urandom_range(0, 9) < 6);
      stl = ($urandom_range(0, 3) == 0);
      rv  = !prev_rv && ($urandom_range(0, 11) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom);
      drive(rdy, stl, rv, rpc);
      model_step(rdy, stl, rv, rpc);
      prev_rv = rv;
      step();
    end
    compare_model();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
